// File: rtl/fwd_scoreboard_unit_if.sv
// Operand-forwarding / hazard bus between the pipeline control and fwd_scoreboard_unit.
// The pipeline side uses the master modport; the unit itself uses the slave modport.
interface fwd_scoreboard_unit_if #(
  parameter int NREG = 32,
  parameter int NSRC = 2,
  parameter int NFWD = 2,
  parameter int LW   = 4
);
  localparam int AW = $clog2(NREG);
  localparam int SW = $clog2(NFWD + 1);

  logic                 flush;
  logic                 decValid;
  logic [NSRC*AW-1:0]   decAddr;
  logic [NSRC*AW-1:0]   exAddr;
  logic                 exLoad;
  logic [AW-1:0]        exRAddr;
  logic [NFWD-1:0]      stgWrite;
  logic [NFWD*AW-1:0]   stgAddr;
  logic                 mcIssue;
  logic [AW-1:0]        mcAddr;
  logic [LW-1:0]        mcLat;
  logic [NSRC*SW-1:0]   fwdSel;
  logic [NSRC-1:0]      decBypass;
  logic                 stall;
  logic [1:0]           stallCause;
  logic                 mcBusy;
  logic [15:0]          stallCount;

  modport master (
    output flush, decValid, decAddr, exAddr, exLoad, exRAddr,
           stgWrite, stgAddr, mcIssue, mcAddr, mcLat,
    input  fwdSel, decBypass, stall, stallCause, mcBusy, stallCount
  );

  modport slave (
    input  flush, decValid, decAddr, exAddr, exLoad, exRAddr,
           stgWrite, stgAddr, mcIssue, mcAddr, mcLat,
    output fwdSel, decBypass, stall, stallCause, mcBusy, stallCount
  );
endinterface

// File: rtl/fwd_scoreboard_unit.sv
// Forwarding/hazard unit: youngest-stage operand forwarding, decode write-through bypass,
// load-use stall and a per-register countdown scoreboard for multi-cycle results.
module fwd_scoreboard_unit #(
  parameter int NREG = 32,
  parameter int NSRC = 2,
  parameter int NFWD = 2,
  parameter int LW   = 4
) (
  input logic            clock,
  input logic            reset,
  fwd_scoreboard_unit_if.slave bus
);
  localparam int AW = $clog2(NREG);
  localparam int SW = $clog2(NFWD + 1);

  typedef enum logic [1:0] {
    CauseNone      = 2'b00,
    CauseLoadUse   = 2'b01,
    CauseMcPending = 2'b10
  } causeT;

  logic [LW-1:0] cnt [NREG];
  logic          issueOk;
  logic          loadUse;
  logic          mcPending;
  logic          busyAny;
  logic [AW-1:0] srcEx;
  logic [AW-1:0] srcDec;
  logic [AW-1:0] stgA;
  logic [SW-1:0] sel;
  causeT         cause;

  assign issueOk = bus.mcIssue && !bus.flush && (bus.mcAddr != '0) && (bus.mcLat != '0);

  // A (re)issue reloads the counter and beats the same-cycle decrement.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (issueOk && (bus.mcAddr == AW'(r))) cnt[r] <= bus.mcLat;
        else if (cnt[r] != '0) cnt[r] <= cnt[r] - 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) bus.stallCount <= '0;
    else if (bus.stall && !bus.flush && (bus.stallCount != 16'hFFFF))
      bus.stallCount <= bus.stallCount + 16'd1;
  end

  // Stages are scanned oldest to youngest so the youngest match is the last one written.
  always_comb begin
    bus.fwdSel    = '0;
    bus.decBypass = '0;
    loadUse       = 1'b0;
    mcPending     = 1'b0;
    srcEx         = '0;
    srcDec        = '0;
    stgA          = '0;
    sel           = '0;
    for (int s = 0; s < NSRC; s++) begin
      srcEx  = bus.exAddr[s*AW +: AW];
      srcDec = bus.decAddr[s*AW +: AW];
      sel    = '0;
      for (int k = NFWD - 1; k >= 0; k--) begin
        stgA = bus.stgAddr[k*AW +: AW];
        if (bus.stgWrite[k] && (stgA != '0) && (stgA == srcEx)) sel = SW'(k + 1);
      end
      bus.fwdSel[s*SW +: SW] = sel;
      stgA = bus.stgAddr[(NFWD-1)*AW +: AW];
      bus.decBypass[s] = bus.stgWrite[NFWD-1] && (stgA != '0) && (stgA == srcDec);
      if (bus.decValid && bus.exLoad && !bus.flush && (bus.exRAddr != '0) &&
          (bus.exRAddr == srcDec))
        loadUse = 1'b1;
      if (bus.decValid && (srcDec != '0) && (cnt[srcDec] != '0))
        mcPending = 1'b1;
    end
  end

  always_comb begin
    busyAny = 1'b0;
    for (int r = 0; r < NREG; r++) busyAny = busyAny | (cnt[r] != '0);
  end

  always_comb begin
    cause = CauseNone;
    if (mcPending) cause = CauseMcPending;
    else if (loadUse) cause = CauseLoadUse;
  end

  assign bus.stall      = loadUse | mcPending;
  assign bus.stallCause = cause;
  assign bus.mcBusy     = busyAny;
endmodule
